// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory request/return, IF/ID delivery and redirect inputs.
interface fetch_ctrl_if;
    logic        stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc;
    logic        ce;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    modport master (
        input  stall, branch_flag_i, branch_target_i, flush_i, new_pc_i,
        input  imem_ack_i, imem_rdata_i,
        output pc, ce, inst_valid_o, inst_o, inst_pc_o
    );

    modport slave (
        output stall, branch_flag_i, branch_target_i, flush_i, new_pc_i,
        output imem_ack_i, imem_rdata_i,
        input  pc, ce, inst_valid_o, inst_o, inst_pc_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one-outstanding memory requests,
// handles redirects (with drop of an in-flight return) and feeds a 2-entry head/skid buffer.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        ce_q, ce_d;
    logic        drop_q, drop_d;
    logic        hd_v_q, hd_v_d;
    logic [31:0] hd_inst_q, hd_inst_d;
    logic [31:0] hd_pc_q, hd_pc_d;
    logic        sk_v_q, sk_v_d;
    logic [31:0] sk_inst_q, sk_inst_d;
    logic [31:0] sk_pc_q, sk_pc_d;

    logic        ack_s;
    logic        consume_s;
    logic        redirect_s;
    logic        push_s;
    logic        issue_ok_s;
    logic [31:0] redir_tgt_s;

    // Per-cycle handshake events and redirect target selection.
    always_comb begin
        ack_s      = ce_q & bus.imem_ack_i;
        consume_s  = hd_v_q & ~bus.stall;
        redirect_s = bus.flush_i | bus.branch_flag_i;
        if (bus.flush_i) begin
            redir_tgt_s = {bus.new_pc_i[31:2], 2'b00};
        end else begin
            redir_tgt_s = {bus.branch_target_i[31:2], 2'b00};
        end
        push_s = ack_s & ~drop_q & ~redirect_s;
    end

    // Head/skid buffer: consume first, then place a return in the first free slot.
    always_comb begin
        hd_v_d    = hd_v_q;
        hd_inst_d = hd_inst_q;
        hd_pc_d   = hd_pc_q;
        sk_v_d    = sk_v_q;
        sk_inst_d = sk_inst_q;
        sk_pc_d   = sk_pc_q;
        if (redirect_s) begin
            hd_v_d = 1'b0;
            sk_v_d = 1'b0;
        end else begin
            if (consume_s) begin
                hd_v_d    = sk_v_q;
                hd_inst_d = sk_inst_q;
                hd_pc_d   = sk_pc_q;
                sk_v_d    = 1'b0;
            end else begin
                hd_v_d = hd_v_q;
            end
            if (push_s) begin
                if (!hd_v_d) begin
                    hd_v_d    = 1'b1;
                    hd_inst_d = bus.imem_rdata_i;
                    hd_pc_d   = pc_q;
                end else begin
                    sk_v_d    = 1'b1;
                    sk_inst_d = bus.imem_rdata_i;
                    sk_pc_d   = pc_q;
                end
            end else begin
                sk_v_d = sk_v_d;
            end
        end
        // A new request is only raised when its return is guaranteed a slot.
        issue_ok_s = ~(hd_v_d & sk_v_d);
    end

    // Sequencer next state: PC, request enable and pending-redirect bookkeeping.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ce_d    = ce_q;
        drop_d  = drop_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                ce_d    = 1'b1;
            end
            ST_RUN: begin
                if (redirect_s) begin
                    if (ce_q && !ack_s) begin
                        drop_d = 1'b1;
                        tgt_d  = redir_tgt_s;
                    end else begin
                        drop_d = 1'b0;
                        pc_d   = redir_tgt_s;
                        ce_d   = issue_ok_s;
                    end
                end else if (ack_s) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                        pc_d   = tgt_q;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                    ce_d = issue_ok_s;
                end else if (!ce_q) begin
                    ce_d = issue_ok_s;
                end else begin
                    ce_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_BOOT;
                ce_d    = 1'b0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            tgt_q     <= 32'h0000_0000;
            ce_q      <= 1'b0;
            drop_q    <= 1'b0;
            hd_v_q    <= 1'b0;
            hd_inst_q <= 32'h0000_0000;
            hd_pc_q   <= 32'h0000_0000;
            sk_v_q    <= 1'b0;
            sk_inst_q <= 32'h0000_0000;
            sk_pc_q   <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            ce_q      <= ce_d;
            drop_q    <= drop_d;
            hd_v_q    <= hd_v_d;
            hd_inst_q <= hd_inst_d;
            hd_pc_q   <= hd_pc_d;
            sk_v_q    <= sk_v_d;
            sk_inst_q <= sk_inst_d;
            sk_pc_q   <= sk_pc_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.ce           = ce_q;
    assign bus.inst_valid_o = hd_v_q;
    assign bus.inst_o       = hd_inst_q;
    assign bus.inst_pc_o    = hd_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios pinned by literals, then randomized
// stall/redirect/wait-state traffic checked every cycle against a queue-based model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    int n_cmp = 0;
    int n_err = 0;

    ent_t        m_q[$];
    logic        m_ce, m_drop, m_boot;
    logic [31:0] m_pc, m_tgt;

    int          waits, mcnt;
    bit          rand_waits, force_ack;
    logic [31:0] key;
    bit          prev_hold;
    logic [31:0] prev_pc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("ce", 32'(bus.ce), 32'(m_ce));
        check("pc", bus.pc, m_pc);
        check("inst_valid", 32'(bus.inst_valid_o), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("inst_pc", bus.inst_pc_o, m_q[0].pc);
            check("inst", bus.inst_o, m_q[0].data);
        end
        if (prev_hold) begin
            check("hold_ce", 32'(bus.ce), 32'd1);
            check("hold_pc", bus.pc, prev_pc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ce      = 1'b0;
        m_pc      = RST_PC;
        m_drop    = 1'b0;
        m_tgt     = 32'd0;
        m_boot    = 1'b1;
        prev_hold = 1'b0;
        mcnt      = 0;
    endtask

    task automatic model_step(input bit ack_in, input bit st, input bit br, input logic [31:0] bt,
                              input bit fl, input logic [31:0] np);
        bit          a;
        ent_t        e;
        logic [31:0] t;
        if (m_boot) begin
            m_boot = 1'b0;
            m_ce   = 1'b1;
        end else begin
            a = m_ce && ack_in;
            if (m_q.size() > 0 && !st) void'(m_q.pop_front());
            if (fl || br) begin
                t = (fl ? np : bt) & 32'hFFFF_FFFC;
                m_q.delete();
                if (m_ce && !a) begin
                    m_drop = 1'b1;
                    m_tgt  = t;
                end else begin
                    m_drop = 1'b0;
                    m_pc   = t;
                    m_ce   = 1'b1;
                end
            end else if (a) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_pc   = m_tgt;
                end else begin
                    e.pc   = m_pc;
                    e.data = m_pc ^ key;
                    m_q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
                m_ce = (m_q.size() <= 1);
            end else if (!m_ce) begin
                m_ce = (m_q.size() <= 1);
            end
        end
    endtask

    // Called at a negedge: check this cycle, drive inputs, advance model, move to next negedge.
    task automatic tick(input bit st, input bit br, input logic [31:0] bt,
                        input bit fl, input logic [31:0] np);
        bit ack;
        compare_model();
        ack = force_ack || (bus.ce && (mcnt >= waits));
        bus.stall           = st;
        bus.branch_flag_i   = br;
        bus.branch_target_i = bt;
        bus.flush_i         = fl;
        bus.new_pc_i        = np;
        bus.imem_ack_i      = ack;
        bus.imem_rdata_i    = ack ? (bus.pc ^ key) : 32'($urandom);
        model_step(ack, st, br, bt, fl, np);
        prev_hold = bus.ce && !ack;
        prev_pc   = bus.pc;
        if (!bus.ce || ack) begin
            mcnt = 0;
            if (rand_waits) waits = $urandom_range(0, 3);
        end else begin
            mcnt++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        bus.imem_ack_i = 1'b1;
        force_ack      = 1'b1;
        #1;
        check("rst_pc", bus.pc, RST_PC);
        check("rst_ce", 32'(bus.ce), 32'd0);
        check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        check("rst_inst", bus.inst_o, 32'd0);
        check("rst_inst_pc", bus.inst_pc_o, 32'd0);
        model_reset();
        @(negedge clk);
        bus.stall         = 1'b0;
        bus.branch_flag_i = 1'b0;
        bus.flush_i       = 1'b0;
        rst               = 1'b1;
    endtask

    initial begin
        rst                 = 1'b1;
        bus.stall           = 1'b0;
        bus.branch_flag_i   = 1'b0;
        bus.branch_target_i = 32'd0;
        bus.flush_i         = 1'b0;
        bus.new_pc_i        = 32'd0;
        bus.imem_ack_i      = 1'b0;
        bus.imem_rdata_i    = 32'd0;
        key        = 32'd0;
        waits      = 0;
        rand_waits = 1'b0;
        force_ack  = 1'b0;
        prev_pc    = 32'd0;
        model_reset();
        @(negedge clk);

        // Reset release with zero-wait memory returning rdata == pc, wrapping past 2^32.
        do_reset();
        check("boot_ce", 32'(bus.ce), 32'd0);
        tick(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        force_ack = 1'b0;
        check("c1_ce", 32'(bus.ce), 32'd1);
        check("c1_pc", bus.pc, 32'hFFFF_FFF8);
        idle(1);
        check("c2_pc", bus.pc, 32'hFFFF_FFFC);
        check("c2_valid", 32'(bus.inst_valid_o), 32'd1);
        check("c2_inst_pc", bus.inst_pc_o, 32'hFFFF_FFF8);
        check("c2_inst", bus.inst_o, 32'hFFFF_FFF8);
        idle(1);
        check("c3_pc", bus.pc, 32'h0000_0000);
        check("c3_inst_pc", bus.inst_pc_o, 32'hFFFF_FFFC);

        // Stall for 5 cycles: buffer fills to 2 and requests stop.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        check("stall_ce", 32'(bus.ce), 32'd0);
        check("stall_head", bus.inst_pc_o, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("release_ce", 32'(bus.ce), 32'd1);
        check("release_pc", bus.pc, 32'h0000_0004);
        check("release_head", bus.inst_pc_o, 32'h0000_0000);

        // Refill to 2 entries, then flush and branch together: flush wins, buffer empties.
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        waits = 3;
        tick(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0180);
        check("flush_valid", 32'(bus.inst_valid_o), 32'd0);
        check("flush_ce", 32'(bus.ce), 32'd1);
        check("flush_pc", bus.pc, 32'h0000_0180);

        // Three wait states: request held 4 cycles.
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("wait_pc", bus.pc, 32'h0000_0180);
        end
        idle(1);
        check("wait_next_pc", bus.pc, 32'h0000_0184);
        check("wait_head", bus.inst_pc_o, 32'h0000_0180);

        // Reset asserted mid-request; a late ack during boot is ignored.
        idle(1);
        do_reset();
        waits = 2;
        tick(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        force_ack = 1'b0;

        // Branch while the 0x20 fetch is outstanding: its data is dropped, pc goes to 0x100.
        tick(1'b0, 1'b1, 32'h0000_0020, 1'b0, 32'd0);
        idle(2);
        check("br20_pc", bus.pc, 32'h0000_0020);
        tick(1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'd0);
        idle(2);
        check("br100_pc", bus.pc, 32'h0000_0100);
        check("br100_valid", 32'(bus.inst_valid_o), 32'd0);
        idle(3);
        check("br100_valid2", 32'(bus.inst_valid_o), 32'd1);
        check("br100_head", bus.inst_pc_o, 32'h0000_0100);

        // Randomized traffic.
        rand_waits = 1'b1;
        key        = $urandom;
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5), $urandom,
                 ($urandom_range(0, 99) < 3), $urandom);
        end
        compare_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request. It issues sequential fetch addresses, applies branch and flush redirects, and handles a memory with variable wait states. It feeds fetched instructions to the IF/ID stage through a 2-entry buffer that absorbs downstream stalls, so no instruction is lost or duplicated. It replaces the free-running PC register at the front of the pipeline.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  IF/ID cannot accept; head entry is not consumed this cycle
- branch_flag_i  in  1  redirect fetch to branch_target_i
- branch_target_i  in  32  branch target address
- flush_i  in  1  exception flush, redirect to new_pc_i; higher priority than branch
- new_pc_i  in  32  flush target address
- imem_ack_i  in  1  current request completes this cycle; may be high in the same cycle as ce
- imem_rdata_i  in  32  instruction word, valid when imem_ack_i is high
- pc  out  32  fetch address to instruction memory
- ce  out  1  instruction-memory request / chip enable
- inst_valid_o  out  1  inst_o / inst_pc_o hold a valid instruction
- inst_o  out  32  fetched instruction
- inst_pc_o  out  32  address of inst_o

## Operation
**States**
- BOOT: entered on reset. ce=0. Moves to RUN on the first clock edge after reset deasserts.
- RUN: ce may be asserted. Stays in RUN until the next reset.

**Request handshake**
- Once ce is raised, ce and pc stay constant until a cycle with imem_ack_i=1. Requests are never withdrawn.
- At most one request is outstanding.

**Issue rule**
- ce is raised for a new address only if the buffer can accept the return, i.e. buffer entries remaining after this edge ≤ 1.
- Buffer entries remaining = entries held, minus 1 if the head is consumed (inst_valid_o && !stall).

**Sequencing**
- On an acked, non-dropped request: data and pc are written into the buffer, and pc advances by 4.
- Arithmetic is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0.

**Buffer**
- 2 entries: head and skid. The head drives inst_*_o.
- On consume, skid moves to head. A new return goes to the first free slot after the consume.
- Order is strictly preserved.

**Redirect**
- Priority: flush_i > branch_flag_i. Redirects apply regardless of stall.
- Target is the selected address with bits [1:0] forced to 0.
- Effect at the edge: both buffer entries are cleared (inst_valid_o=0 next cycle) and pc is set to the target.
- If a request is outstanding and not acked in the redirect cycle:
  - A drop flag is set and pc stays on the old address until the ack.
  - That returned data is discarded, then pc is loaded with the stored target. A later redirect overwrites the stored target.
- If the ack lands in the redirect cycle, the acked data is discarded.

## Timing
- Reset values: pc=RESET_PC, ce=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, buffer empty, drop flag 0, state BOOT.
- Cycle 0 after reset deassertion: ce=0. Cycle 1: ce=1, pc=RESET_PC.
- Ack-to-inst_valid_o latency: 1 cycle (registered).
- Zero-wait memory, no stall: one instruction per cycle, with pc advancing every cycle.
- Redirect with no request pending: the next cycle shows ce=1 and pc=target. The first valid target instruction appears 2 cycles after the redirect with zero-wait memory.
- Stall held indefinitely: at most 2 instructions are buffered and ce stays low.
- After stall drops, the head is consumed on that edge and issue resumes in that same cycle.
- Reset asserted mid-request: everything returns to reset values immediately, and a late ack is ignored because ce=0 in BOOT.

## Test plan
- Reset release, zero-wait memory (ack=ce, rdata=pc) -> ce low 1 cycle, then pc 0,4,8,…; inst_valid_o from cycle 2 with inst_pc_o 0,4,8 and inst_o==inst_pc_o.
- Memory with 3 wait cycles -> pc/ce held for 4 cycles per fetch; exactly one inst_valid_o entry per ack; pc advances by 4 only after each ack.
- Zero-wait memory with stall high for 5 cycles -> ce drops once 2 entries are held; after release the sequence continues with no gap in inst_pc_o and no duplicates.
- Fetch of 0x20 outstanding, branch to 0x103 asserted, ack 2 cycles later -> 0x20 data never appears; next request pc=0x100; next inst_pc_o=0x100.
- flush_i (new_pc_i=0x180) and branch_flag_i (0x100) in the same cycle with 2 buffered entries -> inst_valid_o=0 next cycle; next request pc=0x180.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Then assert rst mid-wait -> pc=RESET_PC, ce=0, inst_valid_o=0 immediately.
